// File: rtl/updown_counter_pkg.sv
// Shared constants and helpers for the parametrised up/down counter.
package updown_counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

    // Operates on 32 bits so it serves every legal WIDTH; callers cast back down.
    function automatic logic [31:0] clamp_load(input logic [31:0] val, input logic [31:0] max);
        return (val > max) ? max : val;
    endfunction

endpackage

// File: rtl/counter_next_calc.sv
// Combinational next-count and boundary-event logic; the top owns all state.
module counter_next_calc
    import updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter logic [WIDTH-1:0] MAX_C   = '1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic [WIDTH-1:0] count_i,
    input  logic             en_i,
    input  logic             dir_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] next_o,
    output logic             up_evt_o,
    output logic             down_evt_o
);

    always_comb begin
        next_o     = count_i;
        up_evt_o   = 1'b0;
        down_evt_o = 1'b0;
        if (load_i) begin
            next_o = WIDTH'(clamp_load(32'(load_val_i), 32'(MAX_C)));
        end else if (en_i) begin
            if (dir_i == DIR_UP) begin
                if (count_i == MAX_C) begin
                    up_evt_o = 1'b1;
                    next_o   = (SATURATE == MODE_SAT) ? MAX_C : '0;
                end else begin
                    next_o = count_i + WIDTH'(1);
                end
            end else begin
                if (count_i == '0) begin
                    down_evt_o = 1'b1;
                    next_o     = (SATURATE == MODE_SAT) ? '0 : MAX_C;
                end else begin
                    next_o = count_i - WIDTH'(1);
                end
            end
        end
    end

endmodule

// File: rtl/updown_counter_param.sv
// Parametrised up/down counter with load, wrap/saturate, terminal-count pulse
// and sticky overflow/underflow flags.
module updown_counter_param
    import updown_counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MAX_VAL  = (64'd1 << WIDTH) - 64'd1,
    parameter int              SATURATE = MODE_WRAP
) (
    input  logic             Clk,
    input  logic             reset,
    input  logic             En,
    input  logic             UpOrDown,
    input  logic             Load,
    input  logic [WIDTH-1:0] LoadVal,
    input  logic             ClrFlags,
    output logic [WIDTH-1:0] Count,
    output logic             Tc,
    output logic             Ovf,
    output logic             Udf,
    output logic             AtMax,
    output logic             AtMin
);

    localparam logic [WIDTH-1:0] MAX_C = MAX_VAL[WIDTH-1:0];

    if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
        $error("updown_counter_param: WIDTH must be in 2..32");
    end
    if (MAX_VAL < 64'd1 || MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
        $error("updown_counter_param: MAX_VAL must be in 1..2**WIDTH-1");
    end

    logic [WIDTH-1:0] count_q, count_d;
    logic             tc_q, ovf_q, udf_q;
    logic             tc_d, ovf_d, udf_d;
    logic             up_evt, down_evt;

    counter_next_calc #(
        .WIDTH    (WIDTH),
        .MAX_C    (MAX_C),
        .SATURATE (SATURATE)
    ) u_next (
        .count_i    (count_q),
        .en_i       (En),
        .dir_i      (UpOrDown),
        .load_i     (Load),
        .load_val_i (LoadVal),
        .next_o     (count_d),
        .up_evt_o   (up_evt),
        .down_evt_o (down_evt)
    );

    // A set event on the same edge as ClrFlags wins.
    always_comb begin
        tc_d  = up_evt | down_evt;
        ovf_d = up_evt   ? 1'b1 : (ClrFlags ? 1'b0 : ovf_q);
        udf_d = down_evt ? 1'b1 : (ClrFlags ? 1'b0 : udf_q);
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ovf_q   <= 1'b0;
            udf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ovf_q   <= ovf_d;
            udf_q   <= udf_d;
        end
    end

    assign Count = count_q;
    assign Tc    = tc_q;
    assign Ovf   = ovf_q;
    assign Udf   = udf_q;
    assign AtMax = (count_q == MAX_C);
    assign AtMin = (count_q == '0);

endmodule
